avalon_sample_slave: RTL and testbench
======================================

// Module: avalon_sample_slave
// PURPOSE
//  Avalon-MM slave that receives one frame of 16-bit samples from the bus and feeds the FFT.
//  Each bus write stores one sample. When the frame is complete it pulses fft_start.
//  The FFT core reads samples back through a private port. Bus status/control uses one register.
// PARAMETERS
//  N_SAMPLES  512  frame length; power of two
//  DATA_W     16   sample / bus data width
//  ADDR_W     10   word address width; MSB=1 selects CSR (word 0x200), MSB=0 selects sample[addr[8:0]]
// PORTS
//  clk                in   1       system clock; all logic on posedge
//  rst                in   1       asynchronous, active-high reset
//  avs_address        in   ADDR_W  word address
//  avs_write          in   1       write request
//  avs_read           in   1       read request
//  avs_writedata      in   DATA_W  write data
//  avs_waitrequest    out  1       stall; the master holds its request while this is 1
//  avs_readdata       out  DATA_W  read data, valid with avs_readdatavalid
//  avs_readdatavalid  out  1       one-cycle strobe, 1 clk after an accepted read
//  sample_addr        in   9       FFT-side buffer read address
//  sample_data        out  DATA_W  mem[sample_addr], registered, 1-clk latency, valid in any state
//  fft_start          out  1       one-cycle pulse: frame ready
//  fft_done           in   1       FFT finished; sampled only in BUSY
//  irq                out  1       overrun interrupt (level); tied 0 unless AVALON_OVERRUN_IRQ_EN
// BEHAVIOUR
//  Reset: state=IDLE, count=0, overrun=0, all outputs=0. Memory is not cleared; reset mid-frame discards the frame.
//  FSM:
//   IDLE -> FILL on the first accepted sample write.
//   FILL -> START on the accepted write that makes count==N_SAMPLES, or on CSR write with bit1=1.
//   START (1 clk, fft_start=1) -> BUSY.
//   BUSY -> DONE on fft_done=1.
//   DONE holds until a CSR clear.
//  Sample write, IDLE/FILL: accepted with waitrequest=0; mem[addr[8:0]]<=writedata; count++ (no wrap; START resets it).
//  Sample write, START/BUSY/DONE: waitrequest=1 (combinational from state, avs_write, address MSB). Memory unchanged.
//  CSR write: bit0=1 clears -> IDLE, count=0, overrun=0, from any state. bit1=1 forces START, only in FILL.
//   Bit0 wins over bit1. Other bits are ignored. CSR writes are never stalled.
//  Reads never stall. readdata/readdatavalid are registered 1 clk after the request.
//   CSR read = {2'b0, done, overrun, state_code[2:0], count[8:0]}; done=(state==DONE).
//   state_code: IDLE=0 FILL=1 START=2 BUSY=3 DONE=4.
//  avs_read and avs_write together: the write is processed, the read is dropped (no readdatavalid).
//  fft_done outside BUSY is ignored. fft_done during a CSR clear: the clear wins.
//  Sample write and FFT read of the same address in one clk: sample_data returns the old word.
// CONFIGURATION
//  AVALON_OVERRUN_IRQ_EN defined:
//   sample writes in START/BUSY/DONE are accepted (waitrequest=0) and the data is discarded.
//   Such a write sets sticky overrun; irq=overrun, cleared by CSR bit0.
//  AVALON_OVERRUN_IRQ_EN undefined: those writes stall as above. overrun stays 0, irq is tied 0.
// STRUCTURE
//  Package avalon_pkg: slave_state_t enum (codes above), CSR_ADDR=10'h200, CSR bit indices, N_SAMPLES default.
//  Sub-module: the existing flex_counter (9-bit) for count; the frame-complete test is done in this module.
//  Sample memory is an inferred 2-read/1-write array inside this module.
// TESTING
//  Reset, then 512 sequential writes of data=addr -> no stalls; fft_start=1 exactly 1 clk after write 512; CSR state=3.
//  In BUSY, write 0x1234 to addr 5 -> waitrequest stays 1; pulse fft_done -> CSR reads 0x2800, write still stalled, mem[5]=5.
//  After the fill, FFT sample_addr=0x1FF -> sample_data=0x01FF next clk. Bus read addr 7 -> readdatavalid 1 clk later, data 7.
//  Write 100 samples, CSR write 0x0002 -> fft_start pulse; CSR count field 100 before the write.
//  In DONE, CSR write 0x0003 -> IDLE, count 0, no fft_start. Assert rst during FILL -> CSR reads 0x0000.
//  With AVALON_OVERRUN_IRQ_EN, write during BUSY -> waitrequest=0, irq=1, overrun bit=1; CSR write 0x0001 -> irq=0.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared types and constants for the Avalon-MM sample slave.
package avalon_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_START = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4
  } slave_state_t;

  localparam int         N_SAMPLES_DEF = 512;
  localparam logic [9:0] CSR_ADDR      = 10'h200;
  localparam int         CSR_CLR_BIT   = 0;
  localparam int         CSR_START_BIT = 1;

  // CSR read layout: {2'b0, done, overrun, state_code[2:0], count[8:0]}
  function automatic logic [15:0] csr_word(input logic done, input logic overrun,
                                           input slave_state_t st, input logic [8:0] cnt);
    return {2'b00, done, overrun, st, cnt};
  endfunction

endpackage

// File: rtl/flex_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
module flex_counter #(
  parameter int NUM_CNT_BITS = 9
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  output logic [NUM_CNT_BITS-1:0] count_out
);

  // count up on enable, hold at all-ones rather than wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     count_out <= '0;
    else if (clear)                              count_out <= '0;
    else if (count_enable && (count_out != '1))  count_out <= count_out + 1'b1;
  end

endmodule

// File: rtl/avalon_sample_slave.sv
// Avalon-MM slave collecting one frame of samples for the FFT.
// Optional feature macro: AVALON_OVERRUN_IRQ_EN -- accept-and-drop writes while
// the frame is owned by the FFT, flag them in a sticky overrun bit driving irq.
module avalon_sample_slave
  import avalon_pkg::*;
#(
  parameter int N_SAMPLES = N_SAMPLES_DEF,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_W-1:0]            avs_address,
  input  logic                         avs_write,
  input  logic                         avs_read,
  input  logic [DATA_W-1:0]            avs_writedata,
  output logic                         avs_waitrequest,
  output logic [DATA_W-1:0]            avs_readdata,
  output logic                         avs_readdatavalid,
  input  logic [$clog2(N_SAMPLES)-1:0] sample_addr,
  output logic [DATA_W-1:0]            sample_data,
  output logic                         fft_start,
  input  logic                         fft_done,
  output logic                         irq
);

  localparam int CNT_W       = $clog2(N_SAMPLES);
  localparam int CSR_SEL_BIT = ADDR_W - 1;

  slave_state_t      state;
  logic [CNT_W-1:0]  count;
  logic              overrun;
  logic [DATA_W-1:0] mem [N_SAMPLES];

  logic [CNT_W-1:0] idx;
  logic csr_sel, smp_sel, frame_owned;
  logic smp_wr, csr_wr, csr_clr, csr_go, frame_full, to_start, rd_acc;
  logic wdata_unused;

  assign idx         = avs_address[CNT_W-1:0];
  assign csr_sel     = avs_address[CSR_SEL_BIT] == CSR_ADDR[CSR_SEL_BIT];
  assign smp_sel     = !csr_sel;
  // once a frame is handed off, the buffer belongs to the FFT until cleared
  assign frame_owned = (state == S_START) || (state == S_BUSY) || (state == S_DONE);

  assign smp_wr     = avs_write && smp_sel && !frame_owned;
  assign csr_wr     = avs_write && csr_sel;
  assign csr_clr    = csr_wr && avs_writedata[CSR_CLR_BIT];
  assign csr_go     = csr_wr && avs_writedata[CSR_START_BIT] && !csr_clr;
  // count is one short of the frame when the last sample arrives
  assign frame_full = smp_wr && (count == CNT_W'(N_SAMPLES - 1));
  assign to_start   = (state == S_FILL) && (frame_full || csr_go);
  // a simultaneous write wins; the read is dropped
  assign rd_acc     = avs_read && !avs_write;

  assign wdata_unused = &{1'b0, avs_writedata[DATA_W-1:2]};

`ifdef AVALON_OVERRUN_IRQ_EN
  assign avs_waitrequest = 1'b0;

  // sticky flag for writes dropped while the FFT owns the frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         overrun <= 1'b0;
    else if (csr_clr)                                overrun <= 1'b0;
    else if (avs_write && smp_sel && frame_owned)    overrun <= 1'b1;
  end
`else
  assign avs_waitrequest = avs_write && smp_sel && frame_owned;
  assign overrun         = 1'b0;
`endif

  assign irq = overrun;

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_cnt (
    .clk          (clk),
    .rst          (rst),
    .clear        (csr_clr || to_start),
    .count_enable (smp_wr),
    .count_out    (count)
  );

  // frame control FSM; fft_start is registered alongside the START entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      fft_start <= 1'b0;
    end else begin
      fft_start <= 1'b0;
      if (csr_clr) state <= S_IDLE;
      else begin
        case (state)
          S_IDLE:  if (smp_wr) state <= S_FILL;
          S_FILL:  if (to_start) begin
                     state     <= S_START;
                     fft_start <= 1'b1;
                   end
          S_START: state <= S_BUSY;
          S_BUSY:  if (fft_done) state <= S_DONE;
          default: ;
        endcase
      end
    end
  end

  // sample buffer write port (contents survive reset)
  always_ff @(posedge clk) begin
    if (smp_wr) mem[idx] <= avs_writedata;
  end

  // registered read ports: FFT side every cycle, bus side on accepted reads
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_data       <= '0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      sample_data       <= mem[sample_addr];
      avs_readdatavalid <= rd_acc;
      if (rd_acc)
        avs_readdata <= csr_sel ? csr_word(state == S_DONE, overrun, state, count) : mem[idx];
    end
  end

endmodule

// File: tb/tb_avalon_sample_slave.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run scored every cycle against a frame-level behavioural model.
module tb_avalon_sample_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic        avs_read = 1'b0;
  logic [15:0] avs_writedata = '0;
  logic        avs_waitrequest;
  logic [15:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [8:0]  sample_addr = '0;
  logic [15:0] sample_data;
  logic        fft_start;
  logic        fft_done = 1'b0;
  logic        irq;

  int checks = 0;
  int errors = 0;

  avalon_sample_slave dut (
    .clk(clk), .rst(rst), .avs_address(avs_address), .avs_write(avs_write),
    .avs_read(avs_read), .avs_writedata(avs_writedata), .avs_waitrequest(avs_waitrequest),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .sample_addr(sample_addr), .sample_data(sample_data), .fft_start(fft_start),
    .fft_done(fft_done), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // states: 0 idle, 1 filling, 2 start pulse, 3 fft busy, 4 done
  int          m_state = 0;
  int          m_count = 0;
  bit          m_ovr = 0;
  logic [15:0] m_mem [512];
  bit          m_ok  [512];
  bit          e_rdv = 0, e_start = 0, e_rdata_ok = 1, e_sdata_ok = 1;
  logic [15:0] e_rdata = '0, e_sdata = '0;

  always @(posedge clk or posedge rst) begin : model
    int  a;
    bit  is_csr;
    if (rst) begin
      m_state = 0; m_count = 0; m_ovr = 0;
      e_rdv = 0; e_start = 0; e_rdata = '0; e_sdata = '0; e_rdata_ok = 1; e_sdata_ok = 1;
    end else begin
      a      = int'(avs_address[8:0]);
      is_csr = avs_address[9];
      e_sdata    = m_mem[sample_addr];
      e_sdata_ok = m_ok[sample_addr];
      e_rdv      = avs_read && !avs_write;
      if (e_rdv) begin
        if (is_csr) begin
          e_rdata    = {2'b00, 1'(m_state == 4), m_ovr, 3'(m_state), 9'(m_count)};
          e_rdata_ok = 1;
        end else begin
          e_rdata    = m_mem[a];
          e_rdata_ok = m_ok[a];
        end
      end
      e_start = 0;
      if (avs_write && is_csr && avs_writedata[0]) begin
        m_state = 0; m_count = 0; m_ovr = 0;
      end else if (avs_write && is_csr) begin
        if (avs_writedata[1] && m_state == 1) begin
          m_state = 2; m_count = 0; e_start = 1;
        end else if (m_state == 2) m_state = 3;
        else if (m_state == 3 && fft_done) m_state = 4;
      end else begin
        if (m_state == 2) m_state = 3;
        else if (m_state == 3 && fft_done) m_state = 4;
        else if (avs_write && m_state <= 1) begin
          m_mem[a] = avs_writedata; m_ok[a] = 1;
          m_count++;
          m_state = 1;
          if (m_count == 512) begin m_state = 2; m_count = 0; e_start = 1; end
        end
`ifdef AVALON_OVERRUN_IRQ_EN
        if (avs_write && m_state >= 2 && !e_start) m_ovr = 1;
`endif
      end
    end
  end

  // compare DUT against the model on every falling edge
  always @(negedge clk) begin : compare
    bit exp_wait;
`ifdef AVALON_OVERRUN_IRQ_EN
    exp_wait = 0;
`else
    exp_wait = avs_write && !avs_address[9] && m_state >= 2;
`endif
    check("waitrequest", 16'(avs_waitrequest), 16'(exp_wait));
    check("fft_start", 16'(fft_start), 16'(e_start));
    check("readdatavalid", 16'(avs_readdatavalid), 16'(e_rdv));
    check("irq", 16'(irq), 16'(m_ovr));
    if ((e_rdv || rst) && e_rdata_ok) check("readdata", avs_readdata, e_rdata);
    if (e_sdata_ok) check("sample_data", sample_data, e_sdata);
  end

  // ---------------- stimulus helpers ----------------
  logic last_wait;

  task automatic cyc(input logic w, input logic r, input logic [9:0] a, input logic [15:0] d);
    avs_write = w; avs_read = r; avs_address = a; avs_writedata = d;
    #1 last_wait = avs_waitrequest;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 10'h000, 16'h0000);
  endtask

  task automatic bus_read(input logic [9:0] a, output logic [15:0] data, output logic vld);
    cyc(1'b0, 1'b1, a, 16'h0000);
    data = avs_readdata; vld = avs_readdatavalid;
    avs_read = 1'b0;
  endtask

  int stalls;
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b0, 10'(i), 16'(i));
      stalls += int'(last_wait);
    end
  endtask

  logic [15:0] rd;
  logic        rv;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    bus_read(10'h200, rd, rv);
    check("reset_csr", rd, 16'h0000);

    // full frame of data=addr
    stalls = 0;
    fill(512);
    check("fill_no_stall", 16'(stalls), 16'd0);
    check("start_after_last", 16'(fft_start), 16'd1);
    idle();
    check("start_one_clk", 16'(fft_start), 16'd0);
    bus_read(10'h200, rd, rv);
    check("csr_busy", rd, 16'h0600);

    // FFT-side and bus-side reads
    sample_addr = 9'h1FF;
    idle();
    check("fft_read_1ff", sample_data, 16'h01FF);
    bus_read(10'h007, rd, rv);
    check("bus_read_vld", 16'(rv), 16'd1);
    check("bus_read_7", rd, 16'h0007);
    idle();
    check("rdv_strobe", 16'(avs_readdatavalid), 16'd0);

    // write while busy stalls; fft_done moves to DONE
    cyc(1'b1, 1'b0, 10'h005, 16'h1234);
    check("busy_stall", 16'(last_wait), 16'd1);
    fft_done = 1'b1;
    cyc(1'b1, 1'b0, 10'h005, 16'h1234);
    fft_done = 1'b0;
    cyc(1'b1, 1'b0, 10'h005, 16'h1234);
    check("done_stall", 16'(last_wait), 16'd1);
    bus_read(10'h200, rd, rv);
    check("csr_done", rd, 16'h2800);
    bus_read(10'h005, rd, rv);
    check("mem5_kept", rd, 16'h0005);

    // clear with both bits set: back to idle, no start
    cyc(1'b1, 1'b0, 10'h200, 16'h0003);
    check("clear_no_start", 16'(fft_start), 16'd0);
    bus_read(10'h200, rd, rv);
    check("csr_cleared", rd, 16'h0000);

    // partial frame, forced start
    fill(100);
    bus_read(10'h200, rd, rv);
    check("csr_fill100", rd, 16'h0264);
    cyc(1'b1, 1'b0, 10'h200, 16'h0002);
    check("forced_start", 16'(fft_start), 16'd1);
    idle();

    // sample write while busy
    cyc(1'b1, 1'b0, 10'h005, 16'hBEEF);
`ifdef AVALON_OVERRUN_IRQ_EN
    check("ovr_no_stall", 16'(last_wait), 16'd0);
    idle();
    check("ovr_irq", 16'(irq), 16'd1);
    bus_read(10'h200, rd, rv);
    check("csr_ovr", rd, 16'h1600);
    cyc(1'b1, 1'b0, 10'h200, 16'h0001);
    check("ovr_irq_clear", 16'(irq), 16'd0);
`else
    check("busy_stall2", 16'(last_wait), 16'd1);
    idle();
    check("irq_tied", 16'(irq), 16'd0);
    cyc(1'b1, 1'b0, 10'h200, 16'h0001);
`endif
    bus_read(10'h005, rd, rv);
    check("mem5_unchanged", rd, 16'h0005);

    // reset mid-fill
    fill(20);
    rst = 1'b1;
    idle();
    rst = 1'b0;
    bus_read(10'h200, rd, rv);
    check("csr_after_rst", rd, 16'h0000);

    // randomized traffic scored by the model
    for (int i = 0; i < 8000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      sample_addr = 9'($urandom);
      fft_done    = ($urandom_range(0, 15) == 0);
      if (r < 600)
        cyc(1'b1, $urandom_range(0, 3) == 0, {1'b0, 9'($urandom)}, 16'($urandom));
      else if (r < 850)
        cyc(1'b0, 1'b1, ($urandom_range(0, 5) == 0) ? 10'h200 : {1'b0, 9'($urandom)}, 16'h0000);
      else if (r < 857)
        cyc(1'b1, $urandom_range(0, 1) == 0, 10'h200, 16'($urandom));
      else if (r < 859) begin
        rst = 1'b1;
        idle();
        rst = 1'b0;
      end else
        idle();
    end
    fft_done = 1'b0;
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
